// File: rtl/alu_exec.sv
// Execute-stage ALU with a valid/ready handshake on both sides.
// Add/sub/logic ops finish in one cycle; shifts are done serially,
// one bit per cycle, by reusing the result register as the shift register.
module alu_exec #(
    parameter  int WIDTH = 16,
    localparam int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       alu_cntl,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             flag_z,
    output logic             flag_c,
    output logic             flag_v
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        HOLD  = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             flag_z_q, flag_z_d;
    logic             flag_c_q, flag_c_d;
    logic             flag_v_q, flag_v_d;
    logic [SHW-1:0]   count_q, count_d;
    logic             dir_right_q, dir_right_d;

    logic [WIDTH:0]   sum_ext;
    logic [WIDTH:0]   diff_ext;
    logic [WIDTH-1:0] alu_res;
    logic             alu_c;
    logic             alu_v;
    logic [SHW-1:0]   shamt;
    logic             is_shift;
    logic             accept;
    logic [WIDTH-1:0] shifted;

    assign shamt    = op_b[SHW-1:0];
    assign is_shift = (alu_cntl[2:1] == 2'b11);
    assign sum_ext  = {1'b0, op_a} + {1'b0, op_b};
    assign diff_ext = {1'b0, op_a} - {1'b0, op_b};

    // A new op can enter when idle, or when the held result leaves this same edge.
    assign in_ready  = rst_n & ((state_q == IDLE) | ((state_q == HOLD) & out_ready));
    assign accept    = in_valid & in_ready;
    assign out_valid = (state_q == HOLD);
    assign result    = result_q;
    assign flag_z    = flag_z_q;
    assign flag_c    = flag_c_q;
    assign flag_v    = flag_v_q;

    // One step of the serial shifter, zero fill in both directions.
    assign shifted = dir_right_q ? {1'b0, result_q[WIDTH-1:1]}
                                 : {result_q[WIDTH-2:0], 1'b0};

    // Single-cycle datapath; a zero-distance shift simply passes op_a through.
    always_comb begin
        alu_res = '0;
        alu_c   = 1'b0;
        alu_v   = 1'b0;
        case (alu_cntl)
            3'b000: begin
                alu_res = sum_ext[WIDTH-1:0];
                alu_c   = sum_ext[WIDTH];
                alu_v   = (op_a[WIDTH-1] == op_b[WIDTH-1]) &
                          (sum_ext[WIDTH-1] != op_a[WIDTH-1]);
            end
            3'b001: begin
                alu_res = diff_ext[WIDTH-1:0];
                alu_c   = diff_ext[WIDTH];
                alu_v   = (op_a[WIDTH-1] != op_b[WIDTH-1]) &
                          (diff_ext[WIDTH-1] != op_a[WIDTH-1]);
            end
            3'b010:  alu_res = op_a & op_b;
            3'b011:  alu_res = op_a | op_b;
            3'b100:  alu_res = op_a ^ op_b;
            3'b101:  alu_res = ~op_a;
            default: alu_res = op_a;
        endcase
    end

    // Next-state and datapath register updates for the IDLE/SHIFT/HOLD controller.
    always_comb begin
        state_d     = state_q;
        result_d    = result_q;
        flag_z_d    = flag_z_q;
        flag_c_d    = flag_c_q;
        flag_v_d    = flag_v_q;
        count_d     = count_q;
        dir_right_d = dir_right_q;
        case (state_q)
            IDLE, HOLD: begin
                if (accept) begin
                    if (is_shift && (shamt != '0)) begin
                        state_d     = SHIFT;
                        result_d    = op_a;
                        count_d     = shamt;
                        dir_right_d = alu_cntl[0];
                        flag_z_d    = 1'b0;
                        flag_c_d    = 1'b0;
                        flag_v_d    = 1'b0;
                    end else begin
                        state_d  = HOLD;
                        result_d = alu_res;
                        flag_z_d = (alu_res == '0);
                        flag_c_d = alu_c;
                        flag_v_d = alu_v;
                    end
                end else if (state_q == HOLD && out_ready) begin
                    state_d = IDLE;
                end
            end
            SHIFT: begin
                result_d = shifted;
                count_d  = count_q - 1'b1;
                if (count_q == SHW'(1)) begin
                    state_d  = HOLD;
                    flag_z_d = (shifted == '0);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers; reset abandons any op in flight.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            result_q    <= '0;
            flag_z_q    <= 1'b0;
            flag_c_q    <= 1'b0;
            flag_v_q    <= 1'b0;
            count_q     <= '0;
            dir_right_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            result_q    <= result_d;
            flag_z_q    <= flag_z_d;
            flag_c_q    <= flag_c_d;
            flag_v_q    <= flag_v_d;
            count_q     <= count_d;
            dir_right_q <= dir_right_d;
        end
    end

endmodule

// File: tb/tb_alu_exec.sv
// Directed testbench for alu_exec (WIDTH=16). Inputs change on the falling
// edge, outputs are sampled on the falling edge.
module tb_alu_exec;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [2:0]  alu_cntl;
    logic [15:0] op_a;
    logic [15:0] op_b;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] result;
    logic        flag_z;
    logic        flag_c;
    logic        flag_v;

    int checks = 0;
    int errors = 0;

    alu_exec #(.WIDTH(16)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .alu_cntl  (alu_cntl),
        .op_a      (op_a),
        .op_b      (op_b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .flag_z    (flag_z),
        .flag_c    (flag_c),
        .flag_v    (flag_v)
    );

    always #5 clk = ~clk;

    // Handshake one op in (called at a falling edge), scramble inputs after the
    // accept edge, and return how many edges until out_valid is seen (-1 on timeout).
    task automatic issue(input logic [2:0] cntl, input logic [15:0] a, input logic [15:0] b,
                         output int lat);
        int guard;
        lat      = -1;
        in_valid = 1'b1;
        alu_cntl = cntl;
        op_a     = a;
        op_b     = b;
        guard    = 0;
        while (!in_ready && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        if (!in_ready) begin
            in_valid = 1'b0;
            return;
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        op_a     = ~a;
        op_b     = ~b;
        alu_cntl = ~cntl;
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk);
            if (out_valid) begin
                lat = c;
                break;
            end
        end
    endtask

    // Let the held result leave for one cycle.
    task automatic take();
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n     = 1'b0;
        in_valid  = 1'b1;
        alu_cntl  = 3'b000;
        op_a      = 16'h0001;
        op_b      = 16'h0001;
        out_ready = 1'b1;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            checks++;
            if ({out_valid, in_ready, result, flag_z, flag_c, flag_v} !== 20'h0) begin
                errors++;
                $display("FAIL reset_state[%0d]: got ov=%b ir=%b res=%h zcv=%b%b%b, want all 0",
                         i, out_valid, in_ready, result, flag_z, flag_c, flag_v);
            end
        end
        in_valid  = 1'b0;
        out_ready = 1'b0;
        rst_n     = 1'b1;
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_release: got ov=%b ir=%b, want ov=0 ir=1", out_valid, in_ready);
        end
        $display("reset: done");
    endtask

    // Add/sub/logic vectors: {cntl, a, b, result, z, c, v}.
    task automatic test_arith();
        logic [2:0]  t_op [11];
        logic [15:0] t_a  [11];
        logic [15:0] t_b  [11];
        logic [18:0] t_exp[11];
        int lat;
        t_op[0]  = 3'b000; t_a[0]  = 16'h7FFF; t_b[0]  = 16'h0001; t_exp[0]  = {16'h8000, 3'b001};
        t_op[1]  = 3'b000; t_a[1]  = 16'hFFFF; t_b[1]  = 16'h0001; t_exp[1]  = {16'h0000, 3'b110};
        t_op[2]  = 3'b001; t_a[2]  = 16'h0003; t_b[2]  = 16'h0005; t_exp[2]  = {16'hFFFE, 3'b010};
        t_op[3]  = 3'b001; t_a[3]  = 16'h8000; t_b[3]  = 16'h0001; t_exp[3]  = {16'h7FFF, 3'b001};
        t_op[4]  = 3'b001; t_a[4]  = 16'h0005; t_b[4]  = 16'h0005; t_exp[4]  = {16'h0000, 3'b100};
        t_op[5]  = 3'b000; t_a[5]  = 16'hFFFF; t_b[5]  = 16'hFFFF; t_exp[5]  = {16'hFFFE, 3'b010};
        t_op[6]  = 3'b010; t_a[6]  = 16'h0F0F; t_b[6]  = 16'h00FF; t_exp[6]  = {16'h000F, 3'b000};
        t_op[7]  = 3'b011; t_a[7]  = 16'h1200; t_b[7]  = 16'h0034; t_exp[7]  = {16'h1234, 3'b000};
        t_op[8]  = 3'b100; t_a[8]  = 16'hAAAA; t_b[8]  = 16'hAAAA; t_exp[8]  = {16'h0000, 3'b100};
        t_op[9]  = 3'b100; t_a[9]  = 16'hA5A5; t_b[9]  = 16'h0FF0; t_exp[9]  = {16'hAA55, 3'b000};
        t_op[10] = 3'b101; t_a[10] = 16'h00FF; t_b[10] = 16'h1234; t_exp[10] = {16'hFF00, 3'b000};
        for (int i = 0; i < 11; i++) begin
            issue(t_op[i], t_a[i], t_b[i], lat);
            checks++;
            if (lat != 1 || {result, flag_z, flag_c, flag_v} !== t_exp[i]) begin
                errors++;
                $display("FAIL arith[%0d]: got lat=%0d res=%h zcv=%b%b%b, want lat=1 res=%h zcv=%b",
                         i, lat, result, flag_z, flag_c, flag_v, t_exp[i][18:3], t_exp[i][2:0]);
            end
            $display("arith[%0d]: op=%b a=%h b=%h -> res=%h zcv=%b%b%b lat=%0d",
                     i, t_op[i], t_a[i], t_b[i], result, flag_z, flag_c, flag_v, lat);
            take();
            checks++;
            if (out_valid !== 1'b0) begin
                errors++;
                $display("FAIL arith_drain[%0d]: got ov=%b, want 0", i, out_valid);
            end
        end
    endtask

    // Shift vectors, with a borrow-producing sub first so cleared C is visible.
    task automatic test_shift();
        logic [2:0]  t_op [7];
        logic [15:0] t_a  [7];
        logic [15:0] t_b  [7];
        logic [18:0] t_exp[7];
        int          t_lat[7];
        int lat;
        t_op[0] = 3'b001; t_a[0] = 16'h0000; t_b[0] = 16'h0001; t_exp[0] = {16'hFFFF, 3'b010}; t_lat[0] = 1;
        t_op[1] = 3'b110; t_a[1] = 16'h0001; t_b[1] = 16'h000F; t_exp[1] = {16'h8000, 3'b000}; t_lat[1] = 16;
        t_op[2] = 3'b111; t_a[2] = 16'h8000; t_b[2] = 16'h0000; t_exp[2] = {16'h8000, 3'b000}; t_lat[2] = 1;
        t_op[3] = 3'b111; t_a[3] = 16'hF000; t_b[3] = 16'h0004; t_exp[3] = {16'h0F00, 3'b000}; t_lat[3] = 5;
        t_op[4] = 3'b110; t_a[4] = 16'h00FF; t_b[4] = 16'h0018; t_exp[4] = {16'hFF00, 3'b000}; t_lat[4] = 9;
        t_op[5] = 3'b110; t_a[5] = 16'h0001; t_b[5] = 16'h0010; t_exp[5] = {16'h0001, 3'b000}; t_lat[5] = 1;
        t_op[6] = 3'b111; t_a[6] = 16'h0001; t_b[6] = 16'h0001; t_exp[6] = {16'h0000, 3'b100}; t_lat[6] = 2;
        for (int i = 0; i < 7; i++) begin
            issue(t_op[i], t_a[i], t_b[i], lat);
            checks++;
            if (lat != t_lat[i] || {result, flag_z, flag_c, flag_v} !== t_exp[i]) begin
                errors++;
                $display("FAIL shift[%0d]: got lat=%0d res=%h zcv=%b%b%b, want lat=%0d res=%h zcv=%b",
                         i, lat, result, flag_z, flag_c, flag_v, t_lat[i], t_exp[i][18:3], t_exp[i][2:0]);
            end
            $display("shift[%0d]: op=%b a=%h b=%h -> res=%h zcv=%b%b%b lat=%0d",
                     i, t_op[i], t_a[i], t_b[i], result, flag_z, flag_c, flag_v, lat);
            take();
        end
    endtask

    task automatic test_backpressure();
        int lat;
        issue(3'b010, 16'h0F0F, 16'h00FF, lat);
        checks++;
        if (lat != 1 || result !== 16'h000F) begin
            errors++;
            $display("FAIL bp_first: got lat=%0d res=%h, want lat=1 res=000f", lat, result);
        end
        // Offer another op while stalled; it must not get in.
        in_valid = 1'b1;
        alu_cntl = 3'b100;
        op_a     = 16'h1111;
        op_b     = 16'h2222;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            checks++;
            if (out_valid !== 1'b1 || in_ready !== 1'b0 || result !== 16'h000F) begin
                errors++;
                $display("FAIL bp_hold[%0d]: got ov=%b ir=%b res=%h, want ov=1 ir=0 res=000f",
                         i, out_valid, in_ready, result);
            end
        end
        in_valid = 1'b0;
        take();
        for (int i = 0; i < 2; i++) begin
            checks++;
            if (out_valid !== 1'b0) begin
                errors++;
                $display("FAIL bp_release[%0d]: got ov=%b, want 0", i, out_valid);
            end
            @(negedge clk);
        end
        $display("backpressure: held 10 cycles, released once");
    endtask

    task automatic test_back_to_back();
        logic [15:0] exp_res[8];
        logic [15:0] a;
        logic [15:0] b;
        out_ready = 1'b1;
        for (int j = 0; j <= 8; j++) begin
            if (j > 0) begin
                checks++;
                if (out_valid !== 1'b1 || result !== exp_res[j-1] || (j < 8 && in_ready !== 1'b1)) begin
                    errors++;
                    $display("FAIL b2b[%0d]: got ov=%b ir=%b res=%h, want ov=1 ir=1 res=%h",
                             j - 1, out_valid, in_ready, result, exp_res[j-1]);
                end
                $display("b2b[%0d]: res=%h", j - 1, result);
            end
            if (j < 8) begin
                a          = 16'h1357 + 16'(j) * 16'h0111;
                b          = 16'h0F0F ^ 16'(j << 4);
                exp_res[j] = a ^ b;
                in_valid   = 1'b1;
                alu_cntl   = 3'b100;
                op_a       = a;
                op_b       = b;
            end else begin
                in_valid = 1'b0;
            end
            @(negedge clk);
        end
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL b2b_end: got ov=%b, want 0 (extra result)", out_valid);
        end
        out_ready = 1'b0;
    endtask

    task automatic test_reset_midshift();
        int lat;
        bit seen;
        in_valid = 1'b1;
        alu_cntl = 3'b110;
        op_a     = 16'h0001;
        op_b     = 16'h000A;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        for (int i = 1; i <= 3; i++) begin
            @(negedge clk);
            checks++;
            if (out_valid !== 1'b0 || in_ready !== 1'b0) begin
                errors++;
                $display("FAIL midshift_busy[%0d]: got ov=%b ir=%b, want 0 0", i, out_valid, in_ready);
            end
        end
        rst_n = 1'b0;
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b0 || result !== 16'h0000) begin
            errors++;
            $display("FAIL midshift_reset: got ov=%b ir=%b res=%h, want 0 0 0000", out_valid, in_ready, result);
        end
        rst_n = 1'b1;
        seen  = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (out_valid) seen = 1'b1;
        end
        checks++;
        if (seen || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL midshift_abandon: got seen_ov=%b ir=%b, want 0 1", seen, in_ready);
        end
        issue(3'b000, 16'h1234, 16'h0001, lat);
        checks++;
        if (lat != 1 || {result, flag_z, flag_c, flag_v} !== {16'h1235, 3'b000}) begin
            errors++;
            $display("FAIL midshift_next: got lat=%0d res=%h zcv=%b%b%b, want lat=1 res=1235 zcv=000",
                     lat, result, flag_z, flag_c, flag_v);
        end
        $display("midshift: next op res=%h lat=%0d", result, lat);
        take();
    endtask

    initial begin
        test_reset();
        test_arith();
        test_shift();
        test_backpressure();
        test_back_to_back();
        test_reset_midshift();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
